ioctl_upload: RTL and testbench

IOCTL_UPLOAD -- requirements
Module: ioctl_upload

---
 rtl/ioctl_upload_pkg.sv | 18 +
 rtl/ioctl_upload_if.sv | 18 +
 rtl/ioctl_upload_spi_tx_shifter.sv | 109 ++++++++++
 rtl/ioctl_upload.sv | 116 +++++++++++
 tb/tb_ioctl_upload.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ioctl_upload_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ioctl_upload_pkg
// Purpose  : Shared width constant and fetch-FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package ioctl_upload_pkg;

    localparam int ADDR_W = 25;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } fetch_state_e;

endpackage : ioctl_upload_pkg
`default_nettype wire

// File: rtl/ioctl_upload_if.sv
`default_nettype none
// ============================================================================
// Module   : ioctl_upload_if
// Purpose  : Byte-read memory port between the uploader and system memory.
// Revision : 1.0 - initial release
// ============================================================================
interface ioctl_upload_if
    import ioctl_upload_pkg::*;
();
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ack;
    logic [7:0]        mem_data;

    modport master (output mem_addr, output mem_rd, input mem_ack, input mem_data);
    modport slave  (input mem_addr, input mem_rd, output mem_ack, output mem_data);
endinterface : ioctl_upload_if
`default_nettype wire

// File: rtl/ioctl_upload_spi_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_tx_shifter
// Purpose  : Mode-0 MSB-first SPI transmitter with sck/ss synchronisers and
//            a load-request/accept handshake towards the byte fetcher.
// Revision : 1.0 - initial release
// ============================================================================
module spi_tx_shifter #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic       clk,
    input  wire logic       nRESET,
    input  wire logic       enable,
    input  wire logic       sck,
    input  wire logic       ss,
    input  wire logic       load_valid,
    input  wire logic [7:0] load_data,
    output logic            load_req,
    output logic            byte_sent,
    output logic            sdo
);

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic                   r_sck_d;
    logic                   r_ss_d;
    logic [2:0]             r_bitcnt;
    logic [7:0]             r_shreg;
    logic [7:0]             r_cur;
    logic                   r_cur_real;
    logic                   r_byte_end;
    logic                   r_resend;

    logic w_sck, w_ss;
    logic w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall;
    logic w_load;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_sck_sync <= '1;
            r_ss_sync  <= '1;
            r_sck_d    <= 1'b1;
            r_ss_d     <= 1'b1;
        end else begin
            r_sck_sync[0] <= sck;
            r_ss_sync[0]  <= ss;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sck_sync[i] <= r_sck_sync[i-1];
                r_ss_sync[i]  <= r_ss_sync[i-1];
            end
            r_sck_d <= w_sck;
            r_ss_d  <= w_ss;
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_ss       = r_ss_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_d & ~w_ss;
    assign w_sck_fall = ~w_sck & r_sck_d & ~w_ss;
    assign w_ss_rise  = w_ss & ~r_ss_d;
    assign w_ss_fall  = ~w_ss & r_ss_d;

    // An ss fall after a mid-byte abort replays cur instead of pulling a new byte
    assign w_load    = enable & ((w_ss_fall & ~r_resend) | (w_sck_fall & r_byte_end));
    assign load_req  = w_load;
    assign byte_sent = enable & w_sck_rise & (r_bitcnt == 3'd7) & r_cur_real;
    assign sdo       = (~w_ss & enable) ? r_shreg[7] : 1'b1;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_bitcnt   <= 3'd0;
            r_shreg    <= 8'hFF;
            r_cur      <= 8'hFF;
            r_cur_real <= 1'b0;
            r_byte_end <= 1'b0;
            r_resend   <= 1'b0;
        end else if (!enable) begin
            r_bitcnt   <= 3'd0;
            r_shreg    <= 8'hFF;
            r_cur      <= 8'hFF;
            r_cur_real <= 1'b0;
            r_byte_end <= 1'b0;
            r_resend   <= 1'b0;
        end else if (w_ss_rise) begin
            if (r_bitcnt != 3'd0) begin
                r_bitcnt <= 3'd0;
                r_shreg  <= r_cur;
                r_resend <= 1'b1;
            end
        end else if (w_load) begin
            r_shreg    <= load_valid ? load_data : 8'hFF;
            r_cur      <= load_valid ? load_data : 8'hFF;
            r_cur_real <= load_valid;
            r_byte_end <= 1'b0;
            r_resend   <= 1'b0;
        end else if (w_ss_fall) begin
            r_resend <= 1'b0;
        end else if (w_sck_rise) begin
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
                r_byte_end <= 1'b1;
            end
        end else if (w_sck_fall) begin
            r_shreg <= {r_shreg[6:0], 1'b1};
        end
    end

endmodule : spi_tx_shifter
`default_nettype wire

// File: rtl/ioctl_upload.sv
`default_nettype none
// ============================================================================
// Module   : ioctl_upload
// Purpose  : Streams a memory region to an SPI host, one byte buffered ahead.
// Revision : 1.0 - initial release
// ============================================================================
module ioctl_upload
    import ioctl_upload_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic              clk,
    input  wire logic              nRESET,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] base,
    input  wire logic [ADDR_W-1:0] size,
    output logic                   busy,
    output logic                   done,
    output logic                   underrun,
    ioctl_upload_if.master         mem,
    input  wire logic              sck,
    input  wire logic              ss,
    output logic                   sdo
);

    fetch_state_e      r_state, w_next;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic [ADDR_W-1:0] r_fetch_left;
    logic [ADDR_W-1:0] r_send_left;
    logic [7:0]        r_hold;
    logic              r_hold_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_underrun;

    logic w_accept, w_empty_start, w_ack, w_load_req, w_byte_sent, w_last;

    assign w_accept      = start & ~r_busy & (r_state == ST_IDLE) & (size != '0);
    assign w_empty_start = start & ~r_busy & (r_state == ST_IDLE) & (size == '0);
    assign w_ack         = mem.mem_ack & (r_state == ST_FETCH);
    assign w_last        = w_byte_sent & (r_send_left == ADDR_W'(1));

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_FETCH;
            ST_FETCH: if (w_ack)    w_next = ST_WAIT;
            ST_WAIT:  if (!r_hold_valid) w_next = (r_fetch_left != '0) ? ST_FETCH : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_fetch_addr <= '0;
            r_fetch_left <= '0;
            r_send_left  <= '0;
            r_hold       <= 8'h00;
            r_hold_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_done <= w_empty_start | w_last;
            if (w_accept) begin
                r_fetch_addr <= base;
                r_fetch_left <= size;
                r_send_left  <= size;
                r_busy       <= 1'b1;
            end else begin
                if (w_ack) begin
                    r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
                    r_fetch_left <= r_fetch_left - ADDR_W'(1);
                end
                if (w_byte_sent) r_send_left <= r_send_left - ADDR_W'(1);
                if (w_last)      r_busy      <= 1'b0;
            end
            // A fresh fetch and a drained load never coincide: FETCH implies hold is empty
            if (w_ack) begin
                r_hold       <= mem.mem_data;
                r_hold_valid <= 1'b1;
            end else if (w_load_req) begin
                r_hold_valid <= 1'b0;
            end
            if (w_load_req && !r_hold_valid) r_underrun <= 1'b1;
        end
    end

    assign mem.mem_rd   = (r_state == ST_FETCH);
    assign mem.mem_addr = r_fetch_addr;
    assign busy         = r_busy;
    assign done         = r_done;
    assign underrun     = r_underrun;

    spi_tx_shifter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_shifter (
        .clk        (clk),
        .nRESET     (nRESET),
        .enable     (r_busy),
        .sck        (sck),
        .ss         (ss),
        .load_valid (r_hold_valid),
        .load_data  (r_hold),
        .load_req   (w_load_req),
        .byte_sent  (w_byte_sent),
        .sdo        (sdo)
    );

endmodule : ioctl_upload
`default_nettype wire

// File: tb/tb_ioctl_upload.sv
`default_nettype none
// ============================================================================
// Module   : tb_ioctl_upload
// Purpose  : Directed self-checking bench for ioctl_upload.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ioctl_upload;
    import ioctl_upload_pkg::*;

    logic              clk = 1'b0;
    logic              nRESET = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base = '0;
    logic [ADDR_W-1:0] size = '0;
    logic              busy, done, underrun;
    logic              sck = 1'b0;
    logic              ss = 1'b1;
    logic              sdo;

    int checks = 0;
    int passed = 0;
    int half = 10;
    int ack_delay = 2;
    int ack_cnt = 0;
    int done_cnt = 0;
    int rd_cnt = 0;
    int busy_cnt = 0;
    logic [ADDR_W-1:0] ack_addr[$];

    ioctl_upload_if mem_bus();

    ioctl_upload #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .nRESET   (nRESET),
        .start    (start),
        .base     (base),
        .size     (size),
        .busy     (busy),
        .done     (done),
        .underrun (underrun),
        .mem      (mem_bus),
        .sck      (sck),
        .ss       (ss),
        .sdo      (sdo)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
        case (a)
            25'h0000100: mem_byte = 8'hA5;
            25'h0000101: mem_byte = 8'h3C;
            25'h0000102: mem_byte = 8'h81;
            25'h0000200: mem_byte = 8'h5A;
            25'h0000201: mem_byte = 8'hC3;
            25'h0000300: mem_byte = 8'h10;
            25'h0000301: mem_byte = 8'h20;
            25'h0000302: mem_byte = 8'h30;
            25'h0000303: mem_byte = 8'h40;
            25'h0000400: mem_byte = 8'h77;
            25'h0000500: mem_byte = 8'hA5;
            25'h1FFFFFF: mem_byte = 8'h11;
            25'h0000000: mem_byte = 8'h22;
            default:     mem_byte = 8'hEE;
        endcase
    endfunction

    // Memory responder: ack ack_delay cycles after mem_rd rises
    initial begin
        mem_bus.mem_ack  = 1'b0;
        mem_bus.mem_data = 8'h00;
    end
    always @(negedge clk) begin
        if (!nRESET) begin
            mem_bus.mem_ack = 1'b0;
            ack_cnt = 0;
        end else if (mem_bus.mem_ack) begin
            mem_bus.mem_ack = 1'b0;
        end else if (mem_bus.mem_rd) begin
            if (ack_cnt >= ack_delay - 1) begin
                mem_bus.mem_ack  = 1'b1;
                mem_bus.mem_data = mem_byte(mem_bus.mem_addr);
                ack_addr.push_back(mem_bus.mem_addr);
                ack_cnt = 0;
            end else begin
                ack_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (done)           done_cnt++;
        if (mem_bus.mem_rd) rd_cnt++;
        if (busy)           busy_cnt++;
    end

    task automatic clear_mon();
        done_cnt = 0;
        rd_cnt   = 0;
        busy_cnt = 0;
        ack_addr.delete();
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s);
        @(negedge clk);
        base  = b;
        size  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic spi_bits(input int n, output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < n; i++) begin
            repeat (half) @(negedge clk);
            b   = {b[6:0], sdo};
            sck = 1'b1;
            repeat (half) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_cnt == 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0)    $display("FAIL reset_busy: got %b want 0", busy);       else passed++;
        checks++; if (done !== 1'b0)    $display("FAIL reset_done: got %b want 0", done);       else passed++;
        checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else passed++;
        checks++; if (mem_bus.mem_rd !== 1'b0) $display("FAIL reset_mem_rd: got %b want 0", mem_bus.mem_rd); else passed++;
        checks++; if (mem_bus.mem_addr !== 25'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_bus.mem_addr); else passed++;
        checks++; if (sdo !== 1'b1)     $display("FAIL reset_sdo: got %b want 1", sdo);         else passed++;
        nRESET = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] b;
        half = 10; ack_delay = 2;
        clear_mon();
        do_start(25'h0000100, 25'd3);
        checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else passed++;
        checks++; if (mem_bus.mem_rd !== 1'b1 || mem_bus.mem_addr !== 25'h0000100)
            $display("FAIL basic_first_rd: got rd=%b addr=%h want rd=1 addr=0000100", mem_bus.mem_rd, mem_bus.mem_addr); else passed++;
        repeat (10) @(negedge clk);
        ss = 1'b0;
        spi_bits(8, b);
        checks++; if (b !== 8'hA5) $display("FAIL basic_byte0: got %h want a5", b); else passed++;
        do_start(25'h0000200, 25'd5);  // ignored while busy
        spi_bits(8, b);
        checks++; if (b !== 8'h3C) $display("FAIL basic_byte1: got %h want 3c", b); else passed++;
        spi_bits(8, b);
        checks++; if (b !== 8'h81) $display("FAIL basic_byte2: got %h want 81", b); else passed++;
        wait_done();
        ss = 1'b1;
        checks++; if (done_cnt !== 1) $display("FAIL basic_done_count: got %0d want 1", done_cnt); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy); else passed++;
        checks++; if (underrun !== 1'b0) $display("FAIL basic_underrun: got %b want 0", underrun); else passed++;
        checks++; if (ack_addr.size() !== 3) $display("FAIL basic_reads: got %0d want 3", ack_addr.size()); else passed++;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_zero_size();
        clear_mon();
        @(negedge clk);
        base = 25'h0000100; size = 25'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b1) $display("FAIL zero_done_pulse: got %b want 1", done); else passed++;
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL zero_done_end: got %b want 0", done); else passed++;
        repeat (10) @(negedge clk);
        checks++; if (rd_cnt !== 0)   $display("FAIL zero_mem_rd: got %0d want 0", rd_cnt); else passed++;
        checks++; if (busy_cnt !== 0) $display("FAIL zero_busy: got %0d want 0", busy_cnt); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL zero_done_count: got %0d want 1", done_cnt); else passed++;
    endtask

    task automatic test_resend();
        logic [7:0] b;
        half = 10; ack_delay = 2;
        clear_mon();
        do_start(25'h0000500, 25'd1);
        repeat (10) @(negedge clk);
        ss = 1'b0;
        spi_bits(4, b);
        checks++; if (b[3:0] !== 4'hA) $display("FAIL resend_first_nibble: got %h want a", b[3:0]); else passed++;
        ss = 1'b1;
        repeat (20) @(negedge clk);
        ss = 1'b0;
        spi_bits(7, b);
        checks++; if (b[6:0] !== 7'h52) $display("FAIL resend_seven_bits: got %h want 52", b[6:0]); else passed++;
        checks++; if (done_cnt !== 0 || busy !== 1'b1)
            $display("FAIL resend_not_consumed: got done_cnt=%0d busy=%b want 0/1", done_cnt, busy); else passed++;
        spi_bits(1, b);
        checks++; if (b[0] !== 1'b1) $display("FAIL resend_last_bit: got %b want 1", b[0]); else passed++;
        wait_done();
        ss = 1'b1;
        checks++; if (done_cnt !== 1) $display("FAIL resend_done_count: got %0d want 1", done_cnt); else passed++;
        checks++; if (underrun !== 1'b0) $display("FAIL resend_underrun: got %b want 0", underrun); else passed++;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_addr_wrap();
        logic [7:0] b;
        half = 10; ack_delay = 2;
        clear_mon();
        do_start(25'h1FFFFFF, 25'd2);
        repeat (10) @(negedge clk);
        ss = 1'b0;
        spi_bits(8, b);
        checks++; if (b !== 8'h11) $display("FAIL wrap_byte0: got %h want 11", b); else passed++;
        spi_bits(8, b);
        checks++; if (b !== 8'h22) $display("FAIL wrap_byte1: got %h want 22", b); else passed++;
        wait_done();
        ss = 1'b1;
        checks++; if (done_cnt !== 1) $display("FAIL wrap_done_count: got %0d want 1", done_cnt); else passed++;
        checks++;
        if (ack_addr.size() != 2)
            $display("FAIL wrap_read_count: got %0d want 2", ack_addr.size());
        else if (ack_addr[0] !== 25'h1FFFFFF || ack_addr[1] !== 25'h0000000)
            $display("FAIL wrap_addrs: got %h,%h want 1ffffff,0000000", ack_addr[0], ack_addr[1]);
        else passed++;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_underrun();
        logic [7:0] b;
        half = 6; ack_delay = 40;
        clear_mon();
        do_start(25'h0000200, 25'd2);
        repeat (2) @(negedge clk);
        ss = 1'b0;
        spi_bits(8, b);
        checks++; if (b !== 8'hFF) $display("FAIL underrun_filler: got %h want ff", b); else passed++;
        checks++; if (underrun !== 1'b1) $display("FAIL underrun_flag: got %b want 1", underrun); else passed++;
        spi_bits(8, b);
        checks++; if (b !== 8'h5A) $display("FAIL underrun_byte0: got %h want 5a", b); else passed++;
        checks++; if (done_cnt !== 0) $display("FAIL underrun_early_done: got %0d want 0", done_cnt); else passed++;
        spi_bits(8, b);
        checks++; if (b !== 8'hC3) $display("FAIL underrun_byte1: got %h want c3", b); else passed++;
        wait_done();
        ss = 1'b1;
        checks++; if (done_cnt !== 1) $display("FAIL underrun_done_count: got %0d want 1", done_cnt); else passed++;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        half = 10; ack_delay = 2;
        clear_mon();
        do_start(25'h0000300, 25'd4);
        repeat (10) @(negedge clk);
        ss = 1'b0;
        spi_bits(8, b);
        checks++; if (b !== 8'h10) $display("FAIL rstmid_byte0: got %h want 10", b); else passed++;
        repeat (3) @(negedge clk);
        nRESET = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || underrun !== 1'b0)
            $display("FAIL rstmid_flags: got busy=%b done=%b underrun=%b want 0/0/0", busy, done, underrun); else passed++;
        checks++; if (mem_bus.mem_rd !== 1'b0 || mem_bus.mem_addr !== 25'h0)
            $display("FAIL rstmid_mem: got rd=%b addr=%h want 0/0000000", mem_bus.mem_rd, mem_bus.mem_addr); else passed++;
        checks++; if (sdo !== 1'b1) $display("FAIL rstmid_sdo: got %b want 1", sdo); else passed++;
        repeat (3) @(negedge clk);
        nRESET = 1'b1;
        ss = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (done_cnt !== 0) $display("FAIL rstmid_no_done: got %0d want 0", done_cnt); else passed++;
        do_start(25'h0000400, 25'd1);
        repeat (10) @(negedge clk);
        ss = 1'b0;
        spi_bits(8, b);
        checks++; if (b !== 8'h77) $display("FAIL rstmid_restart_byte: got %h want 77", b); else passed++;
        wait_done();
        ss = 1'b1;
        checks++; if (done_cnt !== 1) $display("FAIL rstmid_restart_done: got %0d want 1", done_cnt); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rstmid_restart_busy: got %b want 0", busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_size();
        test_resend();
        test_addr_wrap();
        test_underrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_ioctl_upload
`default_nettype wire
